// File: rtl/flash_timer_bank_if.sv
// Control/status bundle between the display controller and the flash timer bank.
// The master drives start/stop/mode/duration; the slave reports busy/done/flash.
interface flash_timer_bank_if #(
    parameter int CHANNELS  = 4,
    parameter int CNT_WIDTH = 16
);
    logic [CHANNELS-1:0]           start;
    logic [CHANNELS-1:0]           stop;
    logic [CHANNELS-1:0]           periodic;
    logic [CHANNELS*CNT_WIDTH-1:0] duration;
    logic [CHANNELS-1:0]           busy;
    logic [CHANNELS-1:0]           done;
    logic [CHANNELS-1:0]           flash;

    modport master (
        output start, stop, periodic, duration,
        input  busy, done, flash
    );

    modport slave (
        input  start, stop, periodic, duration,
        output busy, done, flash
    );
endinterface

// File: rtl/flash_timer_bank.sv
// Bank of independent one-shot/periodic flash timers sharing one free-running
// tick prescaler; each channel counts a programmable number of ticks.
module flash_timer_bank #(
    parameter int CHANNELS  = 4,
    parameter int CNT_WIDTH = 16,
    parameter int PRESCALE  = 50000
) (
    input  logic               CLK_50MHZ,
    input  logic               RST,
    flash_timer_bank_if.slave  bus
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    typedef enum logic {
        IDLE     = 1'b0,
        COUNTING = 1'b1
    } state_t;

    logic [PW-1:0] pre_q, pre_d;
    logic          tick;

    state_t               state_q [CHANNELS];
    state_t               state_d [CHANNELS];
    logic [CNT_WIDTH-1:0] cnt_q   [CHANNELS];
    logic [CNT_WIDTH-1:0] cnt_d   [CHANNELS];
    logic [CNT_WIDTH-1:0] dur_q   [CHANNELS];
    logic [CNT_WIDTH-1:0] dur_d   [CHANNELS];
    logic [CHANNELS-1:0]  mode_q, mode_d;
    logic [CHANNELS-1:0]  done_q, done_d;
    logic [CHANNELS-1:0]  flash_q, flash_d;
    logic [CHANNELS-1:0]  expire;
    logic [CHANNELS-1:0]  busy_c;

    // Shared prescaler is never restarted, so channel phase relative to tick is arbitrary.
    assign tick  = (pre_q == PW'(PRESCALE - 1));
    assign pre_d = tick ? '0 : pre_q + PW'(1);

    always_comb begin
        mode_d  = mode_q;
        done_d  = '0;
        flash_d = flash_q;
        expire  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            dur_d[i]   = dur_q[i];
            // A zero duration expires immediately and is forced to one-shot.
            expire[i]  = (state_q[i] == COUNTING) &&
                         ((dur_q[i] == '0) ||
                          (tick && (cnt_q[i] == dur_q[i] - CNT_WIDTH'(1))));
            if (bus.stop[i]) begin
                state_d[i] = IDLE;
                cnt_d[i]   = '0;
                flash_d[i] = 1'b0;
            end else if (bus.start[i]) begin
                state_d[i] = COUNTING;
                cnt_d[i]   = '0;
                dur_d[i]   = bus.duration[i*CNT_WIDTH +: CNT_WIDTH];
                mode_d[i]  = bus.periodic[i];
                flash_d[i] = 1'b1;
            end else if (expire[i]) begin
                done_d[i] = 1'b1;
                cnt_d[i]  = '0;
                if (mode_q[i] && (dur_q[i] != '0)) begin
                    flash_d[i] = ~flash_q[i];
                end else begin
                    state_d[i] = IDLE;
                    flash_d[i] = 1'b0;
                end
            end else if ((state_q[i] == COUNTING) && tick) begin
                cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge CLK_50MHZ or posedge RST) begin
        if (RST) begin
            pre_q   <= '0;
            mode_q  <= '0;
            done_q  <= '0;
            flash_q <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
                dur_q[i]   <= '0;
            end
        end else begin
            pre_q   <= pre_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
            flash_q <= flash_d;
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                dur_q[i]   <= dur_d[i];
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_busy
        assign busy_c[g] = (state_q[g] == COUNTING);
    end

    assign bus.busy  = busy_c;
    assign bus.done  = done_q;
    assign bus.flash = flash_q;
endmodule

// File: tb/tb_flash_timer_bank.sv
// Bench for flash_timer_bank: two instances (PRESCALE 1 and 4) checked every cycle
// against a remaining-ticks reference model, plus table-driven and directed sequences.
module tb_flash_timer_bank;
    localparam int CH = 4;
    localparam int CW = 8;
    localparam int PA = 1;
    localparam int PB = 4;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    flash_timer_bank_if #(.CHANNELS(CH), .CNT_WIDTH(CW)) ia ();
    flash_timer_bank_if #(.CHANNELS(CH), .CNT_WIDTH(CW)) ib ();

    flash_timer_bank #(.CHANNELS(CH), .CNT_WIDTH(CW), .PRESCALE(PA)) dut_a (
        .CLK_50MHZ(clk), .RST(rst), .bus(ia)
    );
    flash_timer_bank #(.CHANNELS(CH), .CNT_WIDTH(CW), .PRESCALE(PB)) dut_b (
        .CLK_50MHZ(clk), .RST(rst), .bus(ib)
    );

    // Reference model: per channel, ticks remaining until the next expiry.
    bit m_busy  [2][CH];
    bit m_done  [2][CH];
    bit m_flash [2][CH];
    bit m_mode  [2][CH];
    int m_dur   [2][CH];
    int m_left  [2][CH];
    int m_edges;

    typedef struct {
        logic       start;
        logic       stop;
        logic       per;
        logic [7:0] dur;
        logic       busy;
        logic       done;
        logic       flash;
    } vec_t;
    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_edges = 0;
        for (int p = 0; p < 2; p++)
            for (int c = 0; c < CH; c++) begin
                m_busy[p][c] = 0; m_done[p][c] = 0; m_flash[p][c] = 0;
                m_mode[p][c] = 0; m_dur[p][c]  = 0; m_left[p][c]  = 0;
            end
    endtask

    task automatic model_step();
        logic [CH-1:0]    st [2];
        logic [CH-1:0]    sp [2];
        logic [CH-1:0]    pe [2];
        logic [CH*CW-1:0] du [2];
        bit tk [2];
        st[0] = ia.start; sp[0] = ia.stop; pe[0] = ia.periodic; du[0] = ia.duration;
        st[1] = ib.start; sp[1] = ib.stop; pe[1] = ib.periodic; du[1] = ib.duration;
        tk[0] = ((m_edges + 1) % PA) == 0;
        tk[1] = ((m_edges + 1) % PB) == 0;
        m_edges++;
        for (int p = 0; p < 2; p++)
            for (int c = 0; c < CH; c++) begin
                m_done[p][c] = 0;
                if (sp[p][c]) begin
                    m_busy[p][c] = 0; m_flash[p][c] = 0;
                end else if (st[p][c]) begin
                    m_dur[p][c]  = int'(du[p][c*CW +: CW]);
                    m_left[p][c] = m_dur[p][c];
                    m_mode[p][c] = pe[p][c];
                    m_busy[p][c] = 1; m_flash[p][c] = 1;
                end else if (m_busy[p][c] && (m_dur[p][c] == 0 || (tk[p] && m_left[p][c] == 1))) begin
                    m_done[p][c] = 1;
                    if (m_mode[p][c] && m_dur[p][c] != 0) begin
                        m_left[p][c]  = m_dur[p][c];
                        m_flash[p][c] = !m_flash[p][c];
                    end else begin
                        m_busy[p][c] = 0; m_flash[p][c] = 0;
                    end
                end else if (m_busy[p][c] && tk[p]) begin
                    m_left[p][c]--;
                end
            end
    endtask

    task automatic check_model();
        logic [3*CH-1:0] exp [2];
        for (int p = 0; p < 2; p++)
            for (int c = 0; c < CH; c++) begin
                exp[p][2*CH + c] = m_busy[p][c];
                exp[p][CH + c]   = m_done[p][c];
                exp[p][c]        = m_flash[p][c];
            end
        check("model_a", {20'd0, ia.busy, ia.done, ia.flash}, {20'd0, exp[0]});
        check("model_b", {20'd0, ib.busy, ib.done, ib.flash}, {20'd0, exp[1]});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_step();
        check_model();
    endtask

    task automatic clear_inputs();
        ia.start = '0; ia.stop = '0; ia.periodic = '0; ia.duration = '0;
        ib.start = '0; ib.stop = '0; ib.periodic = '0; ib.duration = '0;
    endtask

    task automatic add(input logic s, input logic sp, input logic pe, input logic [7:0] d,
                       input logic b, input logic dn, input logic f);
        vec_t v;
        v.start = s; v.stop = sp; v.per = pe; v.dur = d;
        v.busy = b; v.done = dn; v.flash = f;
        tbl.push_back(v);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int np, busy_drop, n;
        int pt [4];
        int pf [4];
        int first [CH];
        int exp_first [CH];

        // ch0 on instance A (PRESCALE=1): one-shot, retrigger on expiry, start+stop, dur=0 periodic
        add(1, 0, 0, 5, 1, 0, 1);
        for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 1, 0, 1);
        add(0, 0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 4, 1, 0, 1);
        for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 1, 0, 1);
        add(1, 0, 0, 4, 1, 0, 1);
        for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 1, 0, 1);
        add(0, 0, 0, 0, 0, 1, 0);
        add(1, 0, 0, 4, 1, 0, 1);
        add(1, 1, 0, 4, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 1, 0, 1, 0, 1);
        add(0, 0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0);

        rst = 1'b1;
        clear_inputs();
        model_reset();
        #1;
        check("reset_a", {ia.busy, ia.done, ia.flash}, 12'd0);
        check("reset_b", {ib.busy, ib.done, ib.flash}, 12'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step();

        for (int i = 0; i < tbl.size(); i++) begin
            clear_inputs();
            ia.start[0]       = tbl[i].start;
            ia.stop[0]        = tbl[i].stop;
            ia.periodic[0]    = tbl[i].per;
            ia.duration[CW-1:0] = tbl[i].dur;
            step();
            check($sformatf("tbl_row%0d", i), {29'd0, ia.busy[0], ia.done[0], ia.flash[0]},
                  {29'd0, tbl[i].busy, tbl[i].done, tbl[i].flash});
        end
        clear_inputs();

        // Periodic on instance B ch1, dur=3, PRESCALE=4
        ib.start[1] = 1'b1; ib.periodic[1] = 1'b1; ib.duration[2*CW-1:CW] = 8'd3;
        step();
        clear_inputs();
        check("per_start_busy", {31'd0, ib.busy[1]}, 32'd1);
        np = 0; busy_drop = 0;
        for (int t = 1; t <= 80 && np < 4; t++) begin
            step();
            if (!ib.busy[1]) busy_drop = 1;
            if (ib.done[1]) begin
                pt[np] = t; pf[np] = int'(ib.flash[1]); np++;
            end
        end
        check("per_npulses", np, 4);
        check("per_busy_held", busy_drop, 0);
        if (np > 0) check("per_first_window", {31'd0, (pt[0] >= 9 && pt[0] <= 12)}, 32'd1);
        for (int i = 0; i < np; i++) begin
            check($sformatf("per_flash%0d", i), pf[i], i % 2);
            if (i > 0) check($sformatf("per_gap%0d", i), pt[i] - pt[i-1], 12);
        end
        ib.stop[1] = 1'b1;
        step();
        clear_inputs();
        check("per_stop_clear", {29'd0, ib.busy[1], ib.done[1], ib.flash[1]}, 32'd0);
        n = 0;
        for (int t = 0; t < 20; t++) begin
            step();
            if (ib.done[1]) n++;
        end
        check("per_no_pulse_after_stop", n, 0);

        // dur=255 on instance A ch2
        ia.start[2] = 1'b1; ia.duration[3*CW-1:2*CW] = 8'd255;
        step();
        clear_inputs();
        n = 0;
        for (int t = 1; t <= 400; t++) begin
            step();
            if (ia.done[2]) begin
                n = t;
                break;
            end
        end
        check("dur255_latency", n, 255);

        // Independence: all four channels of A on one edge
        ia.start = '1;
        ia.duration = {8'd7, 8'd3, 8'd3, 8'd2};
        step();
        clear_inputs();
        exp_first = '{2, 3, 3, 7};
        for (int c = 0; c < CH; c++) first[c] = 0;
        for (int t = 1; t <= 12; t++) begin
            step();
            for (int c = 0; c < CH; c++)
                if (ia.done[c] && first[c] == 0) first[c] = t;
        end
        for (int c = 0; c < CH; c++) check($sformatf("indep_ch%0d", c), first[c], exp_first[c]);

        // Randomised traffic on both instances
        for (int k = 0; k < 1500; k++) begin
            for (int c = 0; c < CH; c++) begin
                ia.start[c]    = ($urandom_range(0, 15) == 0);
                ia.stop[c]     = ($urandom_range(0, 39) == 0);
                ia.periodic[c] = 1'($urandom_range(0, 1));
                ia.duration[c*CW +: CW] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                                     : 8'($urandom_range(0, 6));
                ib.start[c]    = ($urandom_range(0, 15) == 0);
                ib.stop[c]     = ($urandom_range(0, 39) == 0);
                ib.periodic[c] = 1'($urandom_range(0, 1));
                ib.duration[c*CW +: CW] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 60))
                                                                     : 8'($urandom_range(0, 6));
            end
            step();
        end

        // Mid-count asynchronous reset, between clock edges
        clear_inputs();
        ia.start[1] = 1'b1; ia.duration[2*CW-1:CW] = 8'd50;
        ib.start[3] = 1'b1; ib.periodic[3] = 1'b1; ib.duration[4*CW-1:3*CW] = 8'd20;
        step();
        clear_inputs();
        for (int i = 0; i < 5; i++) step();
        check("pre_reset_busy", {30'd0, ia.busy[1], ib.busy[3]}, 32'd3);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("async_reset_a", {ia.busy, ia.done, ia.flash}, 12'd0);
        check("async_reset_b", {ib.busy, ib.done, ib.flash}, 12'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("post_reset_idle", {ia.busy, ib.busy}, 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/flash_timer_bank.md
# flash_timer_bank

Multi-channel, parametrised flash timer for the scoreboard display path. It supersedes the single fixed-count timer. Each of `CHANNELS` independent channels runs a runtime-programmable duration, measured in prescaled ticks derived from the 50 MHz clock. Each channel operates in one-shot mode or periodic (blink) mode and supports retrigger and abort. The display controller drives `start`/`stop` and consumes `done`, `busy` and `flash` to blink digits and sequence segment flashes.

## Interface
Parameters:
- `CHANNELS`, default 4: number of independent timer channels (≥1).
- `CNT_WIDTH`, default 16: width of each channel's duration and tick counter.
- `PRESCALE`, default 50000: clock cycles per tick (1 ms at 50 MHz). Must be ≥1; a value of 1 gives one tick per cycle.

Ports:
- `CLK_50MHZ`  in  1  system clock; all logic is on the rising edge.
- `RST`  in  1  reset, asynchronous, active-high.
- `start`  in  CHANNELS  per-channel start/retrigger, level-sampled each cycle.
- `stop`  in  CHANNELS  per-channel abort.
- `periodic`  in  CHANNELS  mode select, sampled with `start`: 1 = periodic, 0 = one-shot.
- `duration`  in  CHANNELS*CNT_WIDTH  per-channel tick count; channel i occupies bits [i*CNT_WIDTH +: CNT_WIDTH]. Sampled with `start`.
- `busy`  out  CHANNELS  channel is in COUNTING.
- `done`  out  CHANNELS  one-cycle pulse on each expiry.
- `flash`  out  CHANNELS  display drive level.

## Operation
- Prescaler:
  - One shared free-running counter counts 0..PRESCALE-1 and wraps to 0.
  - `tick` is high during the cycle in which the counter equals PRESCALE-1.
  - The prescaler is not restarted by `start`.
- Per-channel FSM: IDLE, COUNTING.
- Per-channel registers: `cnt` (CNT_WIDTH bits), `dur` (latched duration), `mode` (latched `periodic`), plus the `done` and `flash` output registers.
- Priority within a channel, each edge: `stop` > `start` > expiry > tick increment.
- `stop`, in either state:
  - State goes to IDLE; `cnt` goes to 0; `flash` goes to 0.
  - `done` is not asserted.
- `start` (without `stop`), in either state:
  - Latch `dur` and `mode`; `cnt` goes to 0; state goes to COUNTING; `flash` goes to 1.
  - `done` goes to 0, so a retrigger on an expiry edge suppresses that expiry's pulse.
- Expiry while COUNTING: on a tick cycle with `cnt == dur-1`.
  - One-shot: state goes to IDLE, `done` goes to 1, `flash` goes to 0.
  - Periodic: state stays COUNTING, `cnt` goes to 0, `done` goes to 1, `flash` toggles.
- Tick while COUNTING without expiry: `cnt` increments by 1.
- Non-tick cycles: `cnt` holds.
- `done` is 0 on every edge not listed above; it is never high for two consecutive cycles for a single expiry.
- `dur == 0`:
  - Expiry occurs on the first edge after entering COUNTING, regardless of `tick`.
  - The channel is always treated as one-shot, whatever `periodic` was set to; this prevents a runaway pulse every cycle.
- `cnt` never exceeds `dur-1`, so no wrap is possible. `dur` = 2^CNT_WIDTH-1 is legal.
- Channels are fully independent: simultaneous starts, stops and expiries on different channels do not interact.
- `busy` = (state == COUNTING).

## Timing
- Reset (async, immediate):
  - All channel states go to IDLE; `cnt` and `dur` go to 0.
  - Prescaler goes to 0.
  - `busy`, `done` and `flash` go to 0.
- After `RST` deasserts, the first `tick` is high in cycle PRESCALE, counting the first post-reset cycle as 1.
- Reset mid-count aborts every channel with no `done` pulse.
- `start` is sampled at edge k; `busy` and `flash` are high after edge k.
- One-shot, `dur` = D ≥ 1: `done` is high for one cycle, beginning between 1+(D-1)*PRESCALE and D*PRESCALE edges after edge k. With PRESCALE=1 this is exactly D. `busy` falls on the same edge that `done` rises.
- Periodic: successive `done` pulses are exactly D*PRESCALE cycles apart. `flash` period is 2*D*PRESCALE cycles.
- `dur` = 0: `done` is high after edge k+1.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset: assert `RST` mid-count with no clock edge. Required: `busy`, `done` and `flash` are all 0 immediately; the channel stays IDLE after release.
- One-shot (PRESCALE=1, ch0, `dur`=5): `start` at edge k. Required: `busy` is high for edges k+1..k+4; `done` is high only after edge k+5; `busy` falls at k+5.
- Periodic (PRESCALE=4, ch1, `dur`=3): run 4 periods. Required: `done` pulses are 12 cycles apart; `flash` toggles at each pulse; `busy` stays high; `stop` then clears everything with no pulse.
- Retrigger and priority (PRESCALE=1, `dur`=4):
  - Re-`start` on the expiry edge: no `done`; the new expiry comes 4 edges later.
  - `start` and `stop` together: the channel goes IDLE.
- Boundaries:
  - `dur`=0 with `periodic`=1: a single `done` at k+1, then IDLE.
  - `dur`=255 with CNT_WIDTH=8: `done` after exactly 255 ticks.
- Independence: start all 4 channels on the same edge with `dur`=2,3,3,7 (PRESCALE=1). Required: `done` on ch0 at +2, on ch1 and ch2 together at +3, on ch3 at +7.
